la_capture_core: RTL

Parametrised in-fabric logic-analyzer capture core for on-chip debug of the SPI NOR flash controller and its test sequencer. It continuously samples a DATA_WIDTH probe bus into a circular buffer and holds a programmable pre-trigger window. It fires on a masked value or edge match of a separate trigger bus, then freezes a DEPTH-sample window. The window is read out through a simple addressed port with 1-cycle latency. It sits beside the flash DUT at top level, probing state, serializer/deserializer buffers and SPI pins, and is driven by a host or UART bridge.

---
 rtl/la_pkg.sv | 16 +
 rtl/la_capture_ram.sv | 29 ++
 rtl/la_capture_core.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/la_pkg.sv
// Shared types for the logic-analyzer capture core: FSM states and trigger modes.
package la_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PRETRIG,
    ST_WAIT_TRIG,
    ST_POSTTRIG,
    ST_DONE
  } la_state_e;

  localparam logic [1:0] TRIG_MODE_LEVEL = 2'd0;
  localparam logic [1:0] TRIG_MODE_RISE  = 2'd1;
  localparam logic [1:0] TRIG_MODE_IMM   = 2'd2;

endpackage

// File: rtl/la_capture_ram.sv
// Simple dual-port sample buffer: one write port, one registered read port.
module la_capture_ram #(
  parameter int DATA_WIDTH = 56,
  parameter int DEPTH      = 1024,
  parameter int ADDR_W     = $clog2(DEPTH)
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_we,
  input  logic [ADDR_W-1:0]     i_waddr,
  input  logic [DATA_WIDTH-1:0] i_wdata,
  input  logic                  i_re,
  input  logic [ADDR_W-1:0]     i_raddr,
  output logic [DATA_WIDTH-1:0] o_rdata
);

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];

  always_ff @(posedge i_clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  // Output register reset maps onto the block-RAM output-latch reset; contents are untouched.
  always_ff @(posedge i_clk) begin
    if (i_rst)     o_rdata <= '0;
    else if (i_re) o_rdata <= r_mem[i_raddr];
  end

endmodule

// File: rtl/la_capture_core.sv
// Logic-analyzer capture core: circular pre-trigger buffer, masked level/edge trigger,
// frozen DEPTH-sample window read back oldest-first through a 1-cycle-latency port.
module la_capture_core
  import la_pkg::*;
#(
  parameter int DATA_WIDTH = 56,
  parameter int TRIG_WIDTH = 22,
  parameter int DEPTH      = 1024,
  parameter int ADDR_W     = $clog2(DEPTH)
) (
  input  logic                  crystalClk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] dataIn,
  input  logic [TRIG_WIDTH-1:0] trigIn,
  input  logic [TRIG_WIDTH-1:0] trigValue,
  input  logic [TRIG_WIDTH-1:0] trigMask,
  input  logic [1:0]            trigMode,
  input  logic [ADDR_W-1:0]     preTrigDepth,
  input  logic                  armReq,
  input  logic                  abortReq,
  input  logic                  rdEn,
  input  logic [ADDR_W-1:0]     rdAddr,
  output logic [DATA_WIDTH-1:0] rdData,
  output logic                  rdValid,
  output logic                  busy,
  output logic                  triggered,
  output logic                  done
);

  localparam logic [ADDR_W:0] DEPTH_CNT = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W:0] ONE_CNT   = (ADDR_W + 1)'(1);

  la_state_e             r_state, w_nextState;
  logic [ADDR_W-1:0]     r_wrPtr, r_trigPtr, r_preDepth;
  logic [ADDR_W:0]       r_cnt;
  logic [TRIG_WIDTH-1:0] r_trigValue, r_trigMask;
  logic [1:0]            r_trigMode;
  logic                  r_prevMatch, r_triggered, r_rdVld_p1;

  logic                  w_active, w_armAccept, w_match, w_hit, w_rdAccept;
  logic [ADDR_W:0]       w_cntInc, w_postLen;
  logic [ADDR_W-1:0]     w_startPtr, w_rdPhys;

  always_comb begin
    w_active    = (r_state == ST_PRETRIG) || (r_state == ST_WAIT_TRIG) ||
                  (r_state == ST_POSTTRIG);
    w_armAccept = armReq && ((r_state == ST_IDLE) || (r_state == ST_DONE));
    w_match     = ((trigIn ^ r_trigValue) & r_trigMask) == '0;
    w_hit       = 1'b0;
    if (r_state == ST_WAIT_TRIG) begin
      case (r_trigMode)
        TRIG_MODE_RISE: w_hit = w_match && !r_prevMatch;
        TRIG_MODE_IMM:  w_hit = 1'b1;
        default:        w_hit = w_match;
      endcase
    end
    w_cntInc  = r_cnt + ONE_CNT;
    // Post-trigger length includes the trigger sample itself.
    w_postLen = DEPTH_CNT - {1'b0, r_preDepth};

    w_nextState = r_state;
    case (r_state)
      ST_IDLE, ST_DONE:
        if (armReq) w_nextState = (preTrigDepth == '0) ? ST_WAIT_TRIG : ST_PRETRIG;
      ST_PRETRIG:
        if (w_cntInc == {1'b0, r_preDepth}) w_nextState = ST_WAIT_TRIG;
      ST_WAIT_TRIG:
        if (w_hit) w_nextState = (w_postLen == ONE_CNT) ? ST_DONE : ST_POSTTRIG;
      ST_POSTTRIG:
        if (w_cntInc == w_postLen) w_nextState = ST_DONE;
      default:
        w_nextState = ST_IDLE;
    endcase
    if (abortReq) w_nextState = ST_IDLE;

    w_startPtr = r_trigPtr - r_preDepth;
    w_rdPhys   = w_startPtr + rdAddr;
    w_rdAccept = rdEn && (r_state == ST_DONE);
  end

  always_ff @(posedge crystalClk) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_triggered <= 1'b0;
      r_prevMatch <= 1'b0;
      r_rdVld_p1  <= 1'b0;
    end else begin
      r_state    <= w_nextState;
      r_rdVld_p1 <= w_rdAccept;
      if (abortReq) begin
        r_triggered <= 1'b0;
      end else if (w_armAccept) begin
        r_triggered <= 1'b0;
        r_prevMatch <= 1'b0;
      end else if (w_active) begin
        // Previous-match history runs through PRETRIG so an edge is not faked at WAIT entry.
        r_prevMatch <= w_match;
        if (w_hit) r_triggered <= 1'b1;
      end
    end
  end

  always_ff @(posedge crystalClk) begin
    if (w_armAccept) begin
      r_wrPtr     <= '0;
      r_cnt       <= '0;
      r_preDepth  <= preTrigDepth;
      r_trigValue <= trigValue;
      r_trigMask  <= trigMask;
      r_trigMode  <= trigMode;
    end else if (w_active) begin
      r_wrPtr <= r_wrPtr + 1'b1;
      if (w_hit) begin
        r_trigPtr <= r_wrPtr;
        r_cnt     <= ONE_CNT;
      end else begin
        r_cnt <= w_cntInc;
      end
    end
  end

  la_capture_ram #(
    .DATA_WIDTH(DATA_WIDTH),
    .DEPTH     (DEPTH),
    .ADDR_W    (ADDR_W)
  ) u_ram (
    .i_clk  (crystalClk),
    .i_rst  (reset),
    .i_we   (w_active),
    .i_waddr(r_wrPtr),
    .i_wdata(dataIn),
    .i_re   (w_rdAccept),
    .i_raddr(w_rdPhys),
    .o_rdata(rdData)
  );

  assign rdValid   = r_rdVld_p1;
  assign busy      = w_active;
  assign triggered = r_triggered;
  assign done      = (r_state == ST_DONE);

endmodule
